// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light core: green/yellow/all-red sequencing with a pedestrian
// shortcut, night flashing-yellow, run/hold switch and a BCD countdown of the phase.
module traffic_ctrl_param #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_S   = 25,
    parameter int YELLOW_S  = 3,
    parameter int ALLRED_S  = 2,
    parameter int PED_MIN_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       ped_req,
    output logic [5:0] light,
    output logic [7:0] count,
    output logic [2:0] phase,
    output logic       tick
);

    localparam logic [2:0] AR_A  = 3'd0;
    localparam logic [2:0] A_G   = 3'd1;
    localparam logic [2:0] A_Y   = 3'd2;
    localparam logic [2:0] AR_B  = 3'd3;
    localparam logic [2:0] B_G   = 3'd4;
    localparam logic [2:0] B_Y   = 3'd5;
    localparam logic [2:0] FLASH = 3'd6;

    localparam int         PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

    localparam logic [6:0] D_G   = 7'(GREEN_S);
    localparam logic [6:0] D_Y   = 7'(YELLOW_S);
    localparam logic [6:0] D_AR  = 7'(ALLRED_S);
    localparam logic [6:0] D_PED = 7'(PED_MIN_S);

    logic [PW-1:0] psc_q, psc_d;
    logic [2:0]    state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic          flash_q, flash_d;
    logic [2:0]    nxt;

    function automatic logic [6:0] dur(input logic [2:0] s);
        case (s)
            A_G, B_G: dur = D_G;
            A_Y, B_Y: dur = D_Y;
            default:  dur = D_AR;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    always_comb begin
        case (state_q)
            AR_A:    nxt = A_G;
            A_G:     nxt = A_Y;
            A_Y:     nxt = AR_B;
            AR_B:    nxt = B_G;
            B_G:     nxt = B_Y;
            default: nxt = AR_A;
        endcase
    end

    always_comb begin
        tick  = sw0 && (psc_q == PSC_MAX);
        psc_d = psc_q;
        if (sw0)
            psc_d = tick ? '0 : psc_q + 1'b1;

        state_d = state_q;
        rem_d   = rem_q;
        flash_d = flash_q;
        // Night switch outranks tick and pedestrian, and works even while held.
        if (state_q == FLASH) begin
            if (!sw1) begin
                state_d = AR_A;
                rem_d   = D_AR;
            end else if (tick) begin
                flash_d = !flash_q;
            end
        end else if (sw1) begin
            state_d = FLASH;
            flash_d = 1'b1;
        end else if (state_q == 3'd7) begin
            state_d = AR_A;
            rem_d   = D_AR;
        end else if (tick) begin
            if (rem_q == 7'd1) begin
                state_d = nxt;
                rem_d   = dur(nxt);
            end else begin
                rem_d = rem_q - 7'd1;
            end
        end else if (state_q == A_G && ped_req && rem_q > D_PED) begin
            rem_d = D_PED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q   <= '0;
            state_q <= AR_A;
            rem_q   <= D_AR;
            flash_q <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            state_q <= state_d;
            rem_q   <= rem_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        case (state_q)
            A_G:     light = 6'b001_100;
            A_Y:     light = 6'b010_100;
            B_G:     light = 6'b100_001;
            B_Y:     light = 6'b100_010;
            FLASH:   light = flash_q ? 6'b010_010 : 6'b000_000;
            default: light = 6'b100_100;
        endcase
        count = (state_q == FLASH) ? 8'h00 : to_bcd(rem_q);
        phase = state_q;
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: sequencing, hold, pedestrian, night,
// async reset and BCD decade rollover, with hand-computed expectations.
module tb_traffic_ctrl_param;

    logic       clk = 1'b0;
    logic       rst, sw0, sw1, ped_req;
    logic [5:0] light, light2;
    logic [7:0] count, count2;
    logic [2:0] phase, phase2;
    logic       tick, tick2;

    int errors = 0;
    int checks = 0;

    traffic_ctrl_param #(.TICK_DIV(4), .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(1), .PED_MIN_S(2)) dut (
        .clk(clk), .rst(rst), .sw0(sw0), .sw1(sw1), .ped_req(ped_req),
        .light(light), .count(count), .phase(phase), .tick(tick)
    );

    traffic_ctrl_param #(.TICK_DIV(2), .GREEN_S(12), .YELLOW_S(2), .ALLRED_S(1), .PED_MIN_S(5)) dut2 (
        .clk(clk), .rst(rst), .sw0(sw0), .sw1(sw1), .ped_req(ped_req),
        .light(light2), .count(count2), .phase(phase2), .tick(tick2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles until phase leaves its current value (bounded).
    task automatic dwell(output int n);
        logic [2:0] cur;
        cur = phase;
        n = 0;
        while (phase == cur && n < 200) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input string tag);
        int n;
        n = 0;
        while (phase != p && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, phase, p);
    endtask

    logic [2:0] seq_ph [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [5:0] seq_lt [6] = '{6'b001_100, 6'b010_100, 6'b100_100, 6'b100_001, 6'b100_010, 6'b100_100};
    logic [7:0] seq_ct [6] = '{8'h05, 8'h02, 8'h01, 8'h05, 8'h02, 8'h01};
    int         seq_dw [6] = '{4, 20, 8, 4, 20, 8};

    initial begin
        int n;
        rst = 1'b1; sw0 = 1'b0; sw1 = 1'b0; ped_req = 1'b0;
        step(1);
        chk("rst_light", light, 6'b100_100);
        chk("rst_count", count, 8'h01);
        chk("rst_phase", phase, 0);
        chk("rst_tick",  tick, 0);

        // Normal sequence from reset release
        rst = 1'b0; sw0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dwell(n);
            chk($sformatf("dwell%0d", i), n, seq_dw[i]);
            chk($sformatf("seq_phase%0d", i), phase, seq_ph[i]);
            chk($sformatf("seq_light%0d", i), light, seq_lt[i]);
            chk($sformatf("seq_count%0d", i), count, seq_ct[i]);
        end

        // Hold mid A_G at count 03 with prescaler at 2
        wait_phase(3'd1, "hold_enter");
        step(10);
        chk("hold_pre_count", count, 8'h03);
        sw0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_frozen", {tick, phase, light, count}, {1'b0, 3'd1, 6'b001_100, 8'h03});
        end
        sw0 = 1'b1;
        step(1);
        chk("resume_tick", tick, 1);
        chk("resume_count_a", count, 8'h03);
        step(1);
        chk("resume_count_b", count, 8'h02);

        // Pedestrian shortcut at count 05
        wait_phase(3'd4, "ped_bg");
        wait_phase(3'd1, "ped_ag");
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped_short", count, 8'h02);
        dwell(n);
        chk("ped_to_ay", n, 7);
        chk("ped_ay_phase", phase, 2);

        // Pedestrian at count 02 does nothing
        wait_phase(3'd1, "ped2_ag");
        step(12);
        chk("ped2_pre", count, 8'h02);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped2_noeffect", count, 8'h02);

        // Pedestrian in B_G ignored
        wait_phase(3'd4, "ped3_bg");
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped_bg_ignored", count, 8'h05);

        // Pedestrian coincident with tick: normal decrement wins
        wait_phase(3'd1, "ped4_ag");
        step(3);
        chk("ped4_tick", tick, 1);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped_tick_prec", count, 8'h04);

        // Night mode from B_G
        wait_phase(3'd4, "night_bg");
        sw1 = 1'b1; step(1);
        chk("night_phase", phase, 6);
        chk("night_light_on", light, 6'b010_010);
        chk("night_count", count, 8'h00);
        step(3);
        chk("night_light_off", light, 6'b000_000);
        step(4);
        chk("night_light_on2", light, 6'b010_010);
        sw1 = 1'b0; step(1);
        chk("day_phase", phase, 0);
        chk("day_count", count, 8'h01);
        wait_phase(3'd1, "day_ag");

        // Async reset between edges mid A_Y
        wait_phase(3'd2, "ar_ay");
        step(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_light", light, 6'b100_100);
        chk("arst_phase", phase, 0);
        chk("arst_count", count, 8'h01);
        @(negedge clk) rst = 1'b0;
        dwell(n);
        chk("arst_restart_dwell", n, 4);
        chk("arst_restart_phase", phase, 1);

        // Decade rollover on the second instance
        rst = 1'b1; step(1); rst = 1'b0;
        n = 0;
        while (phase2 != 3'd1 && n < 50) begin
            step(1);
            n++;
        end
        chk("bcd_phase", phase2, 1);
        chk("bcd_12", count2, 8'h12);
        step(2); chk("bcd_11", count2, 8'h11);
        step(2); chk("bcd_10", count2, 8'h10);
        step(2); chk("bcd_09", count2, 8'h09);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
